// File: rtl/input_sequencer.sv
// Button/gamepad conditioner: sync, debounce, shift decode, press detect, and a
// pending queue that emits one-hot strobes. Optional auto-repeat: INPUT_SEQUENCER_AUTOREPEAT_EN.
module input_sequencer #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int HOLD_CYCLES     = 2500,
    parameter int GAP_CYCLES      = 2500,
    parameter int REPEAT_DELAY    = 12500000,
    parameter int REPEAT_PERIOD   = 2500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] btn_in,
    input  logic [2:0] pad_in,
    output logic [7:0] ui_out,
    output logic       busy,
    output logic [7:0] pending,
    output logic [7:0] drop_count
);
    localparam int MAX_DH  = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
    localparam int MAX_GR  = (GAP_CYCLES > REPEAT_DELAY) ? GAP_CYCLES : REPEAT_DELAY;
    localparam int MAX_DHG = (MAX_DH > MAX_GR) ? MAX_DH : MAX_GR;
    localparam int MAX_P   = (MAX_DHG > REPEAT_PERIOD) ? MAX_DHG : REPEAT_PERIOD;
    localparam int CW      = $clog2(MAX_P + 1);

    localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_GAP} state_t;

    logic [8:0]    sync1, sync2, deb;
    logic [CW-1:0] db_cnt [9];
    logic [7:0]    cmd, prev_cmd, ev, drop, accept, clr, hold_mask;
    logic [3:0]    n_drop;
    logic [8:0]    drop_sum;
    logic [2:0]    pick, sel, sel_next;
    logic [CW-1:0] timer, timer_next;
    state_t        state, state_next;
    logic          s;

    // Bits [5:0] are buttons, [8:6] gamepad lines.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {pad_in, btn_in};
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            deb <= '0;
            for (int i = 0; i < 9; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 9; i++) begin
                if (sync2[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    deb[i]    <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign s   = deb[1];
    assign cmd = {deb[5] & s,
                  (deb[4] & s) | deb[8],
                  (deb[0] & s) | deb[7],
                  (deb[0] & ~s) | deb[6],
                  deb[5] & ~s, deb[4] & ~s, deb[3] & ~s, deb[2] & ~s};

`ifdef INPUT_SEQUENCER_AUTOREPEAT_EN
    localparam logic [CW-1:0] REP_D = CW'(REPEAT_DELAY);
    localparam logic [CW-1:0] REP_P = CW'(REPEAT_PERIOD);

    logic [CW-1:0] rep_cnt [4];
    logic [3:0]    rep_armed, syn;
    logic          shift_prev;

    // rep_cnt equals the number of cycles since the press (or last repeat).
    always_comb begin
        syn = '0;
        for (int i = 0; i < 4; i++)
            syn[i] = cmd[i] && (rep_armed[i] ? (rep_cnt[i] == REP_P) : (rep_cnt[i] == REP_D));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_prev <= 1'b0;
            rep_armed  <= '0;
            for (int i = 0; i < 4; i++) rep_cnt[i] <= '0;
        end else begin
            shift_prev <= s;
            for (int i = 0; i < 4; i++) begin
                if (!cmd[i] || (s != shift_prev)) begin
                    rep_cnt[i]   <= '0;
                    rep_armed[i] <= 1'b0;
                end else if (syn[i]) begin
                    rep_cnt[i]   <= {{(CW-1){1'b0}}, 1'b1};
                    rep_armed[i] <= 1'b1;
                end else begin
                    rep_cnt[i] <= rep_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign ev = (cmd & ~prev_cmd) | {4'b0000, syn};
`else
    assign ev = cmd & ~prev_cmd;
`endif

    // An event is dropped if its command is already queued or currently strobing.
    assign hold_mask = (state == ST_HOLD) ? (8'd1 << sel) : 8'd0;
    assign drop      = ev & (pending | hold_mask);
    assign accept    = ev & ~drop;
    assign ui_out    = hold_mask;
    assign busy      = (state != ST_IDLE);

    always_comb begin
        pick = 3'd0;
        for (int i = 7; i >= 0; i--)
            if (pending[i]) pick = 3'(i);
        n_drop = '0;
        for (int i = 0; i < 8; i++)
            n_drop = n_drop + {3'b000, drop[i]};
        drop_sum = {1'b0, drop_count} + {5'b00000, n_drop};
    end

    always_comb begin
        state_next = state;
        timer_next = timer;
        sel_next   = sel;
        clr        = 8'd0;
        case (state)
            ST_IDLE: begin
                if (pending != 8'd0) begin
                    sel_next   = pick;
                    clr        = 8'd1 << pick;
                    timer_next = '0;
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (timer == HOLD_LAST) begin
                    timer_next = '0;
                    state_next = ST_GAP;
                end else begin
                    timer_next = timer + 1'b1;
                end
            end
            ST_GAP: begin
                if (timer == GAP_LAST) begin
                    timer_next = '0;
                    state_next = ST_IDLE;
                end else begin
                    timer_next = timer + 1'b1;
                end
            end
            default: begin
                timer_next = '0;
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            timer      <= '0;
            sel        <= '0;
            prev_cmd   <= '0;
            pending    <= '0;
            drop_count <= '0;
        end else begin
            state      <= state_next;
            timer      <= timer_next;
            sel        <= sel_next;
            prev_cmd   <= cmd;
            pending    <= (pending & ~clr) | accept;
            drop_count <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
        end
    end
endmodule

// File: doc/input_sequencer.md
Name: input_sequencer

Overview:
- Conditions the board's raw push-buttons and gamepad lines and sequences them into clean, one-at-a-time command strobes on the 8-bit game input bus.
- Per input: synchronises, debounces, decodes the shift modifier, and detects presses.
- Queues pending commands, then presents each as a one-hot pulse of fixed width followed by a quiet gap.
- Sits between the board pins and the game core's ui_in, replacing the direct OR of button and gamepad bits.

Parameters:
- DEBOUNCE_CYCLES, 250000, consecutive cycles a synchronised input must differ from its debounced state before the state flips (10 ms at 25 MHz).
- HOLD_CYCLES, 2500, cycles a selected command is held high on ui_out.
- GAP_CYCLES, 2500, cycles ui_out is held all-zero after each hold.
- REPEAT_DELAY, 12500000, cycles before the first auto-repeat (AUTOREPEAT_EN only).
- REPEAT_PERIOD, 2500000, cycles between auto-repeats (AUTOREPEAT_EN only).

Ports:
- clk  in  1  system clock, 25 MHz.
- rst  in  1  synchronous reset, active-high.
- btn_in  in  6  raw buttons: [0]=fire, [1]=shift, [2]=up, [3]=down, [4]=left, [5]=right.
- pad_in  in  3  raw gamepad lines mapping to commands 4,5,6.
- ui_out  out  8  one-hot command strobe: [0]up [1]down [2]left [3]right [4]guess [5]new [6]peek [7]roll.
- busy  out  1  high in HOLD or GAP state.
- pending  out  8  current pending-command register.
- drop_count  out  8  saturating count of dropped duplicate requests.

Behaviour:
- Synchroniser: every btn_in and pad_in bit passes two flops before any other logic.
- Debounce, per bit:
  - Counter resets whenever the synchronised value equals the debounced state.
  - When the counter reaches DEBOUNCE_CYCLES-1 while the values still differ, the debounced state takes the synchronised value and the counter clears.
- Decode, from debounced buttons (s = shift):
  - up=b2&!s, down=b3&!s, left=b4&!s, right=b5&!s, guess=b0&!s.
  - new=b0&s, peek=b4&s, roll=b5&s.
  - Gamepad requests: pad[0]->cmd4, pad[1]->cmd5, pad[2]->cmd6, each from debounced pad bits.
- Request event: rising edge of a decoded command, combining the button and gamepad sources per bit by OR. Toggling shift while a key is held therefore creates an event for the newly decoded command.
- pending[i] is set on an event for command i. If pending[i] is already set, or i is the command currently in HOLD, the event is dropped and drop_count increments, saturating at 255.
- FSM:
  - IDLE: ui_out=0. If pending!=0, select the lowest set index k, clear pending[k], go to HOLD next cycle.
  - HOLD: ui_out=onehot(k) for exactly HOLD_CYCLES cycles, then GAP.
  - GAP: ui_out=0 for exactly GAP_CYCLES cycles, then IDLE.
- Latency:
  - Command pulse begins 2 cycles after pending[k] is set, if idle.
  - Back-to-back commands are separated by HOLD_CYCLES+GAP_CYCLES+1 cycles.
- Set and clear of the same pending bit in one cycle: the set wins only if the event is for a command other than the one being selected. An event for the selected command in that cycle counts as a drop.
- Reset, applied any time including mid-HOLD:
  - Next edge: ui_out=0, busy=0, pending=0, drop_count=0, FSM=IDLE, all counters 0, debounced states and edge history 0.
  - A button held through reset is seen as a fresh press DEBOUNCE_CYCLES+3 cycles after rst deasserts.
- HOLD_CYCLES and GAP_CYCLES must be >=1. Counter widths come from $clog2 of the largest parameter.

Optional Feature:
- Macro: INPUT_SEQUENCER_AUTOREPEAT_EN.
- Defined:
  - For commands 0-3 only, a decoded level held continuously raises a synthetic event after REPEAT_DELAY cycles, then every REPEAT_PERIOD cycles while held.
  - Synthetic events follow the same drop rules.
  - The repeat counter clears on release or on shift change.
- Undefined: only rising edges create events; no repeat logic is synthesised.

Test Plan (DEBOUNCE_CYCLES=4, HOLD_CYCLES=3, GAP_CYCLES=2, REPEAT_DELAY=20, REPEAT_PERIOD=10):
- Reset then btn_in[2] held high -> ui_out=0x01 for exactly 3 cycles, then 0 for 2 cycles. busy high for those 5 cycles. No further pulse while held.
- btn_in[2] high with 1-cycle low glitches every 3 cycles -> no ui_out activity. drop_count=0.
- shift held, then fire pressed -> single 0x20 pulse (new), no 0x10. Release shift with fire still held -> 0x10 pulse follows.
- btn up and pad_in[0] pressed in the same cycle -> pending=0x11. 0x01 pulse, 2-cycle gap, then 0x10 pulse, 6 cycles apart at the rising edges.
- Press/release up twice during a long HOLD of guess -> second event dropped. drop_count=1, exactly one 0x01 pulse after guess.
- rst asserted in second HOLD cycle -> ui_out=0, pending=0 on the next edge. With AUTOREPEAT_EN and down held: pulses of 0x02 at press, then at +20 and every +10 cycles.
